// File: rtl/instr_pack.sv
// instr_pack: packs a stream of 16/32-bit RISC-V instructions into aligned
// 32-bit fetch words; a 32-bit instruction may straddle two words.
module instr_pack #(
    parameter int unsigned FETCH_WIDTH = 32,
    parameter int unsigned VLEN        = 39,
    parameter logic [15:0] NOP_HALF    = 16'h0001
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [VLEN-1:0]        flush_addr_i,
    input  logic                   drain_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instr_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [VLEN-1:0]        address_o,
    output logic [FETCH_WIDTH-1:0] data_o,
    output logic                   unaligned_o
);

    typedef enum logic {
        EMPTY,
        HALF
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            hb_q, hb_d;
    logic                   pend_unal_q, pend_unal_d;
    logic [VLEN-1:0]        addr_cnt_q;
    logic                   free, accept, is_c, do_drain;
    logic                   emit, emit_unal;
    logic [FETCH_WIDTH-1:0] emit_data;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = ^flush_addr_i[1:0];

    assign free          = !valid_o || ready_i;
    assign instr_ready_o = free && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign is_c          = instr_i[1:0] != 2'b11;
    assign do_drain      = drain_i && !instr_valid_i && free && !flush_i
                           && (state_q == HALF);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else if (flush_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept && is_c) state_d = HALF;
            HALF:  if ((accept && is_c) || do_drain) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // In HALF the buffered half always forms the low half of the next word.
    always_comb begin
        emit        = 1'b0;
        emit_data   = instr_i;
        emit_unal   = 1'b0;
        hb_d        = hb_q;
        pend_unal_d = pend_unal_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (is_c) begin
                        hb_d        = instr_i[15:0];
                        pend_unal_d = 1'b0;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            HALF: begin
                emit_data = {instr_i[15:0], hb_q};
                emit_unal = pend_unal_q;
                if (accept) begin
                    emit = 1'b1;
                    if (!is_c) begin
                        hb_d        = instr_i[31:16];
                        pend_unal_d = 1'b1;
                    end
                end else if (do_drain) begin
                    emit      = 1'b1;
                    emit_data = {NOP_HALF, hb_q};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hb_q        <= '0;
            pend_unal_q <= 1'b0;
            addr_cnt_q  <= '0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            address_o   <= '0;
            unaligned_o <= 1'b0;
        end else if (flush_i) begin
            pend_unal_q <= 1'b0;
            addr_cnt_q  <= {flush_addr_i[VLEN-1:2], 2'b00};
            valid_o     <= 1'b0;
        end else begin
            hb_q        <= hb_d;
            pend_unal_q <= pend_unal_d;
            if (emit) begin
                valid_o     <= 1'b1;
                data_o      <= emit_data;
                address_o   <= addr_cnt_q;
                unaligned_o <= emit_unal;
                addr_cnt_q  <= addr_cnt_q + VLEN'(4);
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
